conv_window_gen: RTL and testbench

- Streaming 3x3 window generator. Sits upstream of the 3x3 convolution multiply-accumulate stage and drives its nine window taps and its Cal_Valid.
- Accepts a raster-order pixel stream, one pixel per din_valid cycle.
- Holds the previous two image rows in on-chip line buffers.
- Presents one complete 3x3 neighbourhood for every interior (valid-convolution) output position, with no padding.

---
 rtl/conv_window_gen.sv | 109 ++++++++++
 tb/tb_conv_window_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for a raster pixel stream,
// using two row line buffers and a 3x3 shift register feeding the MAC stage.
module conv_window_gen #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din,
    input  logic                    sof,
    output logic                    Cal_Valid,
    output logic signed [WIDTH-1:0] window_buffer0,
    output logic signed [WIDTH-1:0] window_buffer1,
    output logic signed [WIDTH-1:0] window_buffer2,
    output logic signed [WIDTH-1:0] window_buffer3,
    output logic signed [WIDTH-1:0] window_buffer4,
    output logic signed [WIDTH-1:0] window_buffer5,
    output logic signed [WIDTH-1:0] window_buffer6,
    output logic signed [WIDTH-1:0] window_buffer7,
    output logic signed [WIDTH-1:0] window_buffer8,
    output logic                    frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {FILL, RUN} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d, c;
    logic [RW-1:0]           row_q, row_d, r;
    logic                    last_col, last_row, cal_valid_d, frame_done_d;
    logic signed [WIDTH-1:0] lb1_q [IMG_W];
    logic signed [WIDTH-1:0] lb2_q [IMG_W];
    logic signed [WIDTH-1:0] win_q [9];
    logic signed [WIDTH-1:0] win_d [9];

    // sof re-anchors the accepted pixel at (0,0) whatever the counters say
    assign c        = sof ? '0 : col_q;
    assign r        = sof ? '0 : row_q;
    assign last_col = c == CW'(IMG_W - 1);
    assign last_row = r == RW'(IMG_H - 1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (din_valid)
            state_d = sof ? FILL :
                      (state_q == FILL && r == RW'(1) && last_col) ? RUN :
                      (state_q == RUN && last_row && last_col) ? FILL : state_q;
    end

    always_comb begin
        cal_valid_d  = din_valid && state_q == RUN && c >= CW'(2);
        frame_done_d = cal_valid_d && last_row && last_col;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        if (din_valid) begin
            col_d = last_col ? '0 : c + 1'b1;
            row_d = last_col ? (last_row ? '0 : r + 1'b1) : r;
            win_d = '{win_q[1], win_q[2], lb2_q[c],
                      win_q[4], win_q[5], lb1_q[c],
                      win_q[7], win_q[8], din};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            Cal_Valid  <= 1'b0;
            frame_done <= 1'b0;
            win_q      <= '{default: '0};
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            Cal_Valid  <= cal_valid_d;
            frame_done <= frame_done_d;
            win_q      <= win_d;
        end
    end

    // line buffer contents are always rewritten before use, so no reset
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb2_q[c] <= lb1_q[c];
            lb1_q[c] <= din;
        end
    end

    assign window_buffer0 = win_q[0];
    assign window_buffer1 = win_q[1];
    assign window_buffer2 = win_q[2];
    assign window_buffer3 = win_q[3];
    assign window_buffer4 = win_q[4];
    assign window_buffer5 = win_q[5];
    assign window_buffer6 = win_q[6];
    assign window_buffer7 = win_q[7];
    assign window_buffer8 = win_q[8];
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed scenarios with random idle gaps, checked against
// an image-array reference model of the 3x3 valid-convolution neighbourhoods.
module tb_conv_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic [7:0] din = '0;
    logic       sof = 1'b0;
    logic       Cal_Valid, frame_done;
    logic [7:0] wb [9];

    int         tests = 0;
    int         fails = 0;
    int         pulses = 0;
    int         dones = 0;
    int         mr = 0;
    int         mc = 0;
    logic [7:0] img [H][W];
    logic [7:0] exp_t [9];
    logic       tap_known = 1'b0;
    int         cap_idx = -1;
    int         last_cap = 0;
    logic [7:0] cap_w [9];
    logic [7:0] last_w [9];

    always #5 clk = ~clk;

    conv_window_gen #(.WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .sof(sof),
        .Cal_Valid(Cal_Valid),
        .window_buffer0(wb[0]), .window_buffer1(wb[1]), .window_buffer2(wb[2]),
        .window_buffer3(wb[3]), .window_buffer4(wb[4]), .window_buffer5(wb[5]),
        .window_buffer6(wb[6]), .window_buffer7(wb[7]), .window_buffer8(wb[8]),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, model the accepted pixel, check at next negedge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic rs);
        logic ecv, efd;
        din_valid = v; din = d; sof = s; rst = rs;
        ecv = 1'b0; efd = 1'b0;
        if (rs) begin
            mr = 0; mc = 0; tap_known = 1'b1;
            for (int k = 0; k < 9; k++) exp_t[k] = '0;
        end else if (v) begin
            if (s) begin mr = 0; mc = 0; end
            img[mr][mc] = d;
            if (mr >= 2 && mc >= 2) begin
                ecv = 1'b1;
                efd = (mr == H - 1 && mc == W - 1);
                tap_known = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_t[i*3+j] = img[mr-2+i][mc-2+j];
            end else tap_known = 1'b0;
            mc++;
            if (mc == W) begin mc = 0; mr = (mr == H - 1) ? 0 : mr + 1; end
        end
        @(negedge clk);
        chk("cal_valid", 32'(Cal_Valid), 32'(ecv));
        chk("frame_done", 32'(frame_done), 32'(efd));
        if (tap_known)
            for (int k = 0; k < 9; k++) chk($sformatf("tap%0d", k), 32'(wb[k]), 32'(exp_t[k]));
        if (Cal_Valid) begin
            if (pulses == cap_idx) cap_w = wb;
            last_w = wb;
            pulses++;
        end
        if (frame_done) dones++;
    endtask

    task automatic frame(input int off, input logic s, input int max_idle, input int npix);
        for (int k = 0; k < npix; k++) begin
            int gap;
            gap = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
            for (int g = 0; g < gap; g++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
            cyc(1'b1, 8'(off + (k / W) * 16 + (k % W)), s && k == 0, 1'b0);
        end
    endtask

    task automatic chk_win(input string tag, input logic [7:0] w [9], input logic [7:0] base);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                chk($sformatf("%s_%0d", tag, i*3+j), 32'(w[i*3+j]), 32'(base + 8'(i*16 + j)));
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) chk("reset_tap", 32'(wb[k]), 32'h0);

        pulses = 0; dones = 0; cap_idx = 0;
        frame(0, 1'b1, 0, W * H);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s1_pulses", 32'(pulses), 32'(6));
        chk("s1_dones", 32'(dones), 32'(1));
        chk_win("s1_first", cap_w, 8'h00);
        chk_win("s1_last", last_w, 8'h12);

        pulses = 0; dones = 0;
        for (int n = 0; n < 3; n++) frame(0, 1'b1, 3, W * H);
        chk("s2_pulses", 32'(pulses), 32'(18));
        chk("s2_dones", 32'(dones), 32'(3));

        pulses = 0; dones = 0; cap_idx = 6;
        frame(0, 1'b1, 0, W * H);
        frame(8'h40, 1'b0, 0, W * H);
        chk("s3_pulses", 32'(pulses), 32'(12));
        chk("s3_dones", 32'(dones), 32'(2));
        chk_win("s3_second_first", cap_w, 8'h40);

        pulses = 0; dones = 0; cap_idx = 1;
        frame(0, 1'b1, 1, 2 * W + 3);
        frame(8'h80, 1'b1, 1, W * H);
        chk("s4_pulses", 32'(pulses), 32'(7));
        chk_win("s4_restart_first", cap_w, 8'h80);

        pulses = 0; dones = 0; cap_idx = 3;
        frame(0, 1'b1, 0, 3 * W + 1);
        cyc(1'b1, 8'h31, 1'b0, 1'b1);
        chk("s5_rst_cv", 32'(Cal_Valid), 32'h0);
        frame(0, 1'b0, 0, W * H);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s5_pulses", 32'(pulses), 32'(9));
        chk("s5_dones", 32'(dones), 32'(1));
        chk_win("s5_first", cap_w, 8'h00);
        chk_win("s5_last", last_w, 8'h12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
